// File: rtl/n2c_rx_pkg.sv
// n2c_rx_pkg: shared types and constants for the n2c receive framer.
package n2c_rx_pkg;

    // Receive framing state
    typedef enum logic [1:0] {
        HUNT,
        PAY,
        CHK,
        SYNC
    } rx_state_t;

    // Default frame header pattern
    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;

    // Width of the error statistics counters
    localparam int CNT_W = 16;

endpackage

// File: rtl/n2c_rx_framer_if.sv
// n2c_rx_framer_if: word-stream handshake between the framer and nm_if.
interface n2c_rx_framer_if #(
    parameter int WORD_W = 16,
    parameter int CH_W   = 6
) ();

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/n2c_rx_bank.sv
// n2c_rx_bank: ping-pong frame storage, 2 x NUM_CH x WORD_W, registered read.
module n2c_rx_bank #(
    parameter int WORD_W = 16,
    parameter int NUM_CH = 64,
    parameter int CH_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              fill_sel,
    input  logic [1:0]        full,
    input  logic              rd_en,
    input  logic              rd_sel,
    input  logic [CH_W-1:0]   rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2][NUM_CH];

    // Payload write into the fill bank; a bank holding a complete frame is never overwritten
    always_ff @(posedge clk) begin
        if (wr_en && !full[fill_sel]) begin
            mem[fill_sel][wr_idx] <= wr_data;
        end
    end

    // Registered read of the drain bank, cleared on reset so out_data starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en && full[rd_sel]) begin
            rd_data <= mem[rd_sel][rd_idx];
        end
    end

endmodule

// File: rtl/n2c_rx_framer.sv
// n2c_rx_framer: hunts for the sync word in the n2c bit stream, assembles
// NUM_CH-word frames, checks the XOR checksum and releases good frames one
// word per handshake from a ping-pong buffer.
// Optional build macro N2C_RX_STATS_EN enables the crc_cnt/ovf_cnt counters;
// without it both counters are tied to 0.
module n2c_rx_framer
    import n2c_rx_pkg::*;
#(
    parameter int          WORD_W    = 16,
    parameter int          NUM_CH    = 64,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int          CH_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n2c_bit_en,
    input  logic             n2c_data,
    n2c_rx_framer_if.master  out_if,
    output logic             locked,
    output logic             crc_err,
    output logic             ovf_err,
    output logic [CNT_W-1:0] crc_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    // Shifter must hold both a payload word and the 16-bit header
    localparam int SH_W = (WORD_W > 16) ? WORD_W : 16;
    localparam int BC_W = $clog2(SH_W);

    rx_state_t         state;
    logic [SH_W-1:0]   shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CH_W-1:0]   wr_idx;
    logic [WORD_W-1:0] xor_acc;
    logic              drop_frame;
    logic              fill_sel;
    logic              drain_sel;
    logic [1:0]        full;

    logic              wr_en_p1;
    logic [CH_W-1:0]   wr_idx_p1;
    logic [WORD_W-1:0] wr_data_p1;

    logic              out_valid_q;
    logic [CH_W-1:0]   rd_idx;
    logic [WORD_W-1:0] rd_data;

    logic [SH_W-1:0]   sh_next;
    logic [WORD_W-1:0] word_next;
    logic [15:0]       sync_next;
    logic              word_done;
    logic              sync_done;
    logic              hs;
    logic              hs_last;
    logic              fill_freed;
    logic              rd_en;
    logic [CH_W-1:0]   rd_addr;

    // Next-bit view of the shifter and drain handshake decode
    always_comb begin
        sh_next    = {shreg[SH_W-2:0], n2c_data};
        word_next  = sh_next[WORD_W-1:0];
        sync_next  = sh_next[15:0];
        word_done  = (bit_cnt == BC_W'(WORD_W - 1));
        sync_done  = (bit_cnt == BC_W'(15));
        hs         = out_valid_q && out_if.out_ready;
        hs_last    = hs && (rd_idx == CH_W'(NUM_CH - 1));
        // A bank released in the same cycle a frame starts counts as empty
        fill_freed = hs_last && (drain_sel == fill_sel);
        rd_en      = (hs && !hs_last) || (!out_valid_q && full[drain_sel]);
        rd_addr    = hs ? rd_idx + 1'b1 : rd_idx;
    end

    // Receive FSM: sync hunt, payload assembly, checksum and bank hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            shreg      <= '0;
            bit_cnt    <= '0;
            wr_idx     <= '0;
            xor_acc    <= '0;
            drop_frame <= 1'b0;
            locked     <= 1'b0;
            crc_err    <= 1'b0;
            ovf_err    <= 1'b0;
            fill_sel   <= 1'b0;
            full       <= '0;
            wr_en_p1   <= 1'b0;
        end else begin
            crc_err  <= 1'b0;
            ovf_err  <= 1'b0;
            wr_en_p1 <= 1'b0;
            if (hs_last) begin
                full[drain_sel] <= 1'b0;
            end
            if (n2c_bit_en) begin
                shreg <= sh_next;
                case (state)
                    HUNT: begin
                        if (sync_next == SYNC_WORD) begin
                            state      <= PAY;
                            locked     <= 1'b1;
                            bit_cnt    <= '0;
                            wr_idx     <= '0;
                            xor_acc    <= '0;
                            drop_frame <= full[fill_sel] && !fill_freed;
                        end
                    end
                    PAY: begin
                        if (word_done) begin
                            bit_cnt    <= '0;
                            wr_en_p1   <= !drop_frame;
                            wr_idx_p1  <= wr_idx;
                            wr_data_p1 <= word_next;
                            xor_acc    <= xor_acc ^ word_next;
                            wr_idx     <= wr_idx + 1'b1;
                            if (wr_idx == CH_W'(NUM_CH - 1)) begin
                                state <= CHK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    CHK: begin
                        if (word_done) begin
                            bit_cnt <= '0;
                            if (word_next != xor_acc) begin
                                crc_err <= 1'b1;
                                locked  <= 1'b0;
                                state   <= HUNT;
                            end else begin
                                state <= SYNC;
                                if (drop_frame) begin
                                    ovf_err <= 1'b1;
                                end else begin
                                    full[fill_sel] <= 1'b1;
                                    fill_sel       <= ~fill_sel;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (sync_done) begin
                            bit_cnt <= '0;
                            if (sync_next == SYNC_WORD) begin
                                state      <= PAY;
                                wr_idx     <= '0;
                                xor_acc    <= '0;
                                drop_frame <= full[fill_sel] && !fill_freed;
                            end else begin
                                locked <= 1'b0;
                                state  <= HUNT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Drain side: present the full bank word by word, release it after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rd_idx      <= '0;
            drain_sel   <= 1'b0;
        end else if (hs_last) begin
            out_valid_q <= 1'b0;
            rd_idx      <= '0;
            drain_sel   <= ~drain_sel;
        end else if (hs) begin
            rd_idx <= rd_idx + 1'b1;
        end else if (!out_valid_q && full[drain_sel]) begin
            out_valid_q <= 1'b1;
        end
    end

    n2c_rx_bank #(
        .WORD_W (WORD_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_p1),
        .wr_idx   (wr_idx_p1),
        .wr_data  (wr_data_p1),
        .fill_sel (fill_sel),
        .full     (full),
        .rd_en    (rd_en),
        .rd_sel   (drain_sel),
        .rd_idx   (rd_addr),
        .rd_data  (rd_data)
    );

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = rd_data;
    assign out_if.out_ch    = rd_idx;
    assign out_if.out_last  = out_valid_q && (rd_idx == CH_W'(NUM_CH - 1));

`ifdef N2C_RX_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Saturating error statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (crc_err) crc_cnt <= sat_inc(crc_cnt);
            if (ovf_err) ovf_cnt <= sat_inc(ovf_cnt);
        end
    end
`else
    assign crc_cnt = '0;
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_n2c_rx_framer.sv
// tb_n2c_rx_framer: scoreboard bench for n2c_rx_framer.
module tb_n2c_rx_framer;
    import n2c_rx_pkg::*;

    localparam int WORD_W = 16;
    localparam int NUM_CH = 64;
    localparam int CH_W   = 6;
`ifdef N2C_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n2c_bit_en = 1'b0;
    logic        n2c_data = 1'b0;
    logic        locked, crc_err, ovf_err;
    logic [15:0] crc_cnt, ovf_cnt;

    n2c_rx_framer_if #(.WORD_W(WORD_W), .CH_W(CH_W)) out_if ();

    n2c_rx_framer #(
        .WORD_W    (WORD_W),
        .NUM_CH    (NUM_CH),
        .SYNC_WORD (SYNC_WORD_DEF),
        .CH_W      (CH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .n2c_bit_en (n2c_bit_en),
        .n2c_data   (n2c_data),
        .out_if     (out_if),
        .locked     (locked),
        .crc_err    (crc_err),
        .ovf_err    (ovf_err),
        .crc_cnt    (crc_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          crc_seen = 0;
    int          ovf_seen = 0;
    int          hs_count = 0;
    logic [22:0] sb [$];
    logic [15:0] fw [NUM_CH];
    bit          duty_mode = 1'b0;
    bit          rand_ready = 1'b0;
    bit          ready_lvl = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // out_ready driver, updated a little after each rising edge
    initial begin
        out_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability
    initial begin
        logic        stall_prev;
        logic [22:0] prev_word;
        logic [22:0] cur;
        logic [22:0] exp;
        stall_prev = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (crc_err) crc_seen++;
            if (ovf_err) ovf_seen++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                cur = {out_if.out_last, out_if.out_ch, out_if.out_data};
                if (stall_prev) begin
                    check("stall_valid", 32'(out_if.out_valid), 32'd1);
                    check("stall_hold", 32'(cur), 32'(prev_word));
                end
                if (out_if.out_valid && out_if.out_ready) begin
                    hs_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", cur);
                    end else begin
                        exp = sb.pop_front();
                        check("word", 32'(cur), 32'(exp));
                    end
                end
                stall_prev = out_if.out_valid && !out_if.out_ready;
                prev_word  = cur;
            end
        end
    end

    task automatic send_bit(input logic b);
        bit done;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (!duty_mode || $urandom_range(0, 9) < 3) begin
                n2c_bit_en = 1'b1;
                n2c_data   = b;
                done       = 1'b1;
            end else begin
                n2c_bit_en = 1'b0;
                n2c_data   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n2c_bit_en = 1'b0;
            n2c_data   = 1'b0;
        end
    endtask

    // Optional zero lead-in, header, fw[] payload, checksum xor flip
    task automatic send_frame(input logic [15:0] sync, input logic [15:0] flip,
                              input bit lead, input bit expect_out);
        logic [15:0] x;
        x = '0;
        if (expect_out)
            for (int ch = 0; ch < NUM_CH; ch++)
                sb.push_back({(ch == NUM_CH - 1), 6'(ch), fw[ch]});
        if (lead) send_word(16'h0000);
        send_word(sync);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            send_word(fw[ch]);
            x = x ^ fw[ch];
        end
        send_word(x ^ flip);
        idle(1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words left expected 0", name, sb.size());
        end
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        ready_lvl  = 1'b0;
        n2c_bit_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 32'(out_if.out_valid), 32'd0);
        check({name, "_data"},  32'(out_if.out_data),  32'd0);
        check({name, "_ch"},    32'(out_if.out_ch),    32'd0);
        check({name, "_last"},  32'(out_if.out_last),  32'd0);
        check({name, "_locked"}, 32'(locked),          32'd0);
        check({name, "_crc_err"}, 32'(crc_err),        32'd0);
        check({name, "_ovf_err"}, 32'(ovf_err),        32'd0);
        check({name, "_crc_cnt"}, 32'(crc_cnt),        32'd0);
        check({name, "_ovf_cnt"}, 32'(ovf_cnt),        32'd0);
    endtask

    initial begin
        int base_crc;
        int base_hs;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // 1: one good frame, words ch*3
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(ch * 3);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        wait_drain("t1");
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_crc_seen", 32'(crc_seen), 32'd0);

        // 2: checksum bit 0 flipped, then a good frame
        send_frame(SYNC_WORD_DEF, 16'h0001, 1'b0, 1'b0);
        idle(4);
        check("t2_crc_pulse", 32'(crc_seen), 32'd1);
        check("t2_crc_cnt", 32'(crc_cnt), STATS ? 32'd1 : 32'd0);
        check("t2_valid", 32'(out_if.out_valid), 32'd0);
        check("t2_locked", 32'(locked), 32'd0);
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(ch * 3 + 1);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b1, 1'b1);
        wait_drain("t2");
        check("t2_relock", 32'(locked), 32'd1);

        // 3: three back-to-back frames with the consumer stalled
        ready_lvl = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'h1000 + ch);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'h2000 + ch * 5);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'hBEEF ^ ch);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b0);
        idle(4);
        check("t3_ovf_pulse", 32'(ovf_seen), 32'd1);
        check("t3_ovf_cnt", 32'(ovf_cnt), STATS ? 32'd1 : 32'd0);
        check("t3_valid_stalled", 32'(out_if.out_valid), 32'd1);
        check("t3_first_word", 32'(out_if.out_data), 32'h1000);
        check("t3_queue", 32'(sb.size()), 32'd128);
        ready_lvl = 1'b1;
        wait_drain("t3");

        // 4: 30% bit strobe duty and random out_ready
        duty_mode  = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'($urandom);
            send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        end
        wait_drain("t4");
        duty_mode  = 1'b0;
        rand_ready = 1'b0;
        check("t4_crc_seen", 32'(crc_seen), 32'd1);
        check("t4_ovf_seen", 32'(ovf_seen), 32'd1);

        // 5a: reset at word 20 of a frame
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'h5000 + ch * 7);
        send_word(SYNC_WORD_DEF);
        for (int ch = 0; ch < 20; ch++) send_word(fw[ch]);
        do_reset();
        check_zero("t5a");
        ready_lvl = 1'b1;
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        wait_drain("t5a");

        // 5b: reset in the middle of a drain
        ready_lvl = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'h7700 + ch);
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        n = 0;
        while (!out_if.out_valid && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("t5b_valid_seen", 32'(out_if.out_valid), 32'd1);
        base_hs   = hs_count;
        ready_lvl = 1'b1;
        n = 0;
        while (hs_count < base_hs + 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        do_reset();
        check_zero("t5b");
        ready_lvl = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'h0F0F ^ (ch << 4));
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b0, 1'b1);
        wait_drain("t5b");
        check("t5b_locked", 32'(locked), 32'd1);

        // 6: corrupt header after a good frame, then re-lock
        base_crc = crc_seen;
        send_word(16'hA5C2);
        idle(3);
        check("t6_unlocked", 32'(locked), 32'd0);
        check("t6_no_crc", 32'(crc_seen), 32'(base_crc));
        for (int ch = 0; ch < NUM_CH; ch++) fw[ch] = 16'(16'hC000 | (ch * 11));
        send_frame(SYNC_WORD_DEF, 16'h0000, 1'b1, 1'b1);
        wait_drain("t6");
        check("t6_relock", 32'(locked), 32'd1);
        check("t6_crc_final", 32'(crc_seen), 32'(base_crc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
